vc_buffer: RTL and testbench

- Single-clock synchronous FIFO that buffers flits for one virtual channel in a router input port.
- Accepts one word per cycle on write and delivers one word per cycle on read.
- Reports occupancy, full and empty status, and an error flag for illegal accesses.
- Sits between the link receiver and the VC allocator/switch logic.

---
 rtl/vc_buffer.sv | 94 +++++++++
 tb/tb_vc_buffer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/vc_buffer.sv
// Single-clock flit FIFO for one virtual channel of a router input port.
// Registered read data (1-cycle latency), occupancy counter, full/empty decode and an
// illegal-access error flag. Optional macro VC_BUFFER_STICKY_ERROR_EN makes the error
// flag sticky until reset; by default it pulses for one cycle per illegal access.
module vc_buffer #(
  parameter int unsigned MSB_SLOT = 5,
  parameter int unsigned ADDRSIZE = 5,
  parameter int unsigned DSIZE    = 32,
  parameter int unsigned DEPTH    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                write_en,
  input  logic                read_en,
  input  logic [DSIZE-1:0]    data_in,
  output logic [DSIZE-1:0]    data_out,
  output logic                error,
  output logic                full,
  output logic                empty,
  output logic [MSB_SLOT:0]   ocup
);

  localparam logic [MSB_SLOT:0] DepthCnt = (MSB_SLOT + 1)'(DEPTH);

  logic [DSIZE-1:0]    fifo_ff [DEPTH];
  logic [ADDRSIZE-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDRSIZE-1:0] rd_ptr_q, rd_ptr_d;
  logic [MSB_SLOT:0]   ocup_q, ocup_d;
  logic [DSIZE-1:0]    data_out_q, data_out_d;
  logic                error_q, error_d;

  logic read_accept;
  logic write_accept;
  logic illegal;

  // Status decodes and access acceptance; a full FIFO still takes a write if a read frees a slot.
  always_comb begin
    full         = (ocup_q == DepthCnt);
    empty        = (ocup_q == '0);
    read_accept  = read_en && !empty;
    write_accept = write_en && (!full || read_accept);
    illegal      = (write_en && !write_accept) || (read_en && !read_accept);
  end

  // Next-state for pointers, occupancy, read data and error flag.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    ocup_d     = ocup_q;
    data_out_d = data_out_q;
    if (write_accept) wr_ptr_d = wr_ptr_q + ADDRSIZE'(1);
    if (read_accept) begin
      rd_ptr_d   = rd_ptr_q + ADDRSIZE'(1);
      data_out_d = fifo_ff[rd_ptr_q];
    end
    unique case ({write_accept, read_accept})
      2'b10:   ocup_d = ocup_q + (MSB_SLOT + 1)'(1);
      2'b01:   ocup_d = ocup_q - (MSB_SLOT + 1)'(1);
      default: ocup_d = ocup_q;
    endcase
`ifdef VC_BUFFER_STICKY_ERROR_EN
    error_d = error_q | illegal;
`else
    error_d = illegal;
`endif
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ocup_q     <= '0;
      data_out_q <= '0;
      error_q    <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ocup_q     <= ocup_d;
      data_out_q <= data_out_d;
      error_q    <= error_d;
    end
  end

  // Storage write; contents are deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (reset && write_accept) fifo_ff[wr_ptr_q] <= data_in;
  end

  assign data_out = data_out_q;
  assign error    = error_q;
  assign ocup     = ocup_q;

endmodule

// File: tb/tb_vc_buffer.sv
// Directed self-checking bench for vc_buffer.
module tb_vc_buffer;

  localparam int unsigned MSB_SLOT = 5;
  localparam int unsigned ADDRSIZE = 5;
  localparam int unsigned DSIZE    = 32;
  localparam int unsigned DEPTH    = 32;

`ifdef VC_BUFFER_STICKY_ERROR_EN
  localparam bit Sticky = 1'b1;
`else
  localparam bit Sticky = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              write_en;
  logic              read_en;
  logic [DSIZE-1:0]  data_in;
  logic [DSIZE-1:0]  data_out;
  logic              error;
  logic              full;
  logic              empty;
  logic [MSB_SLOT:0] ocup;

  int total = 0;
  int bad   = 0;
  bit err_seen = 1'b0;

  always #5 clk = ~clk;

  vc_buffer #(
    .MSB_SLOT (MSB_SLOT),
    .ADDRSIZE (ADDRSIZE),
    .DSIZE    (DSIZE),
    .DEPTH    (DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .write_en (write_en),
    .read_en  (read_en),
    .data_in  (data_in),
    .data_out (data_out),
    .error    (error),
    .full     (full),
    .empty    (empty),
    .ocup     (ocup)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of stimulus, then sample 1 time unit after the rising edge.
  task automatic step(input logic we, input logic re, input logic [31:0] d);
    write_en = we;
    read_en  = re;
    data_in  = d;
    @(posedge clk);
    #1;
  endtask

  // Expected error: pulse on illegal access, or held once seen when sticky.
  function automatic logic [31:0] exp_err(input bit pulse);
    if (pulse) err_seen = 1'b1;
    return 32'(pulse | (Sticky & err_seen));
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    step(1'b0, 1'b0, 32'h0);
    reset = 1'b1;
    err_seen = 1'b0;
  endtask

  initial begin
    reset    = 1'b0;
    write_en = 1'b0;
    read_en  = 1'b0;
    data_in  = '0;

    // Reset state
    do_reset();
    check("rst_ocup", 32'(ocup), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_dout", data_out, 32'h0);

    // Three writes, then one read
    step(1'b1, 1'b0, 32'h0101A5A5);
    step(1'b1, 1'b0, 32'h0000BBBB);
    step(1'b1, 1'b0, 32'h00010001);
    check("w3_ocup", 32'(ocup), 32'd3);
    check("w3_empty", 32'(empty), 32'd0);
    step(1'b0, 1'b1, 32'h0);
    check("r1_dout", data_out, 32'h0101A5A5);
    check("r1_ocup", 32'(ocup), 32'd2);

    // Simultaneous read+write mid-occupancy
    step(1'b1, 1'b1, 32'h0100CCCC);
    check("rw_dout", data_out, 32'h0000BBBB);
    check("rw_ocup", 32'(ocup), 32'd2);
    step(1'b0, 1'b1, 32'h0);
    check("r2_dout", data_out, 32'h00010001);
    step(1'b0, 1'b1, 32'h0);
    check("r3_dout", data_out, 32'h0100CCCC);
    check("r3_ocup", 32'(ocup), 32'd0);
    check("r3_empty", 32'(empty), 32'd1);
    check("r3_error", 32'(error), exp_err(1'b0));

    // Underflow read
    step(1'b0, 1'b1, 32'h0);
    check("uf_error", 32'(error), exp_err(1'b1));
    check("uf_dout", data_out, 32'h0100CCCC);
    check("uf_ocup", 32'(ocup), 32'd0);
    step(1'b0, 1'b0, 32'h0);
    check("uf_error_next", 32'(error), exp_err(1'b0));

    // Fill to full with 0..31
    for (int i = 0; i < 32; i++) step(1'b1, 1'b0, 32'(i));
    check("fill_full", 32'(full), 32'd1);
    check("fill_ocup", 32'(ocup), 32'd32);
    check("fill_empty", 32'(empty), 32'd0);

    // Overflow write
    step(1'b1, 1'b0, 32'hDEADBEEF);
    check("of_error", 32'(error), exp_err(1'b1));
    check("of_ocup", 32'(ocup), 32'd32);

    // Read+write while full
    step(1'b1, 1'b1, 32'd32);
    check("frw_ocup", 32'(ocup), 32'd32);
    check("frw_full", 32'(full), 32'd1);
    check("frw_dout", data_out, 32'd0);
    check("frw_error", 32'(error), exp_err(1'b0));
    step(1'b0, 1'b1, 32'h0);
    check("frw_next_dout", data_out, 32'd1);

    // Mid-operation reset discards contents
    do_reset();
    check("mrst_ocup", 32'(ocup), 32'd0);
    check("mrst_empty", 32'(empty), 32'd1);
    check("mrst_error", 32'(error), 32'd0);
    check("mrst_dout", data_out, 32'h0);

    // Read+write while empty: write accepted, read rejected
    step(1'b1, 1'b1, 32'h12345678);
    check("erw_ocup", 32'(ocup), 32'd1);
    check("erw_error", 32'(error), exp_err(1'b1));
    check("erw_dout", data_out, 32'h0);
    step(1'b0, 1'b1, 32'h0);
    check("erw_read", data_out, 32'h12345678);
    check("erw_ocup0", 32'(ocup), 32'd0);

    // Wrap-around: 48 writes, 40 reads interleaved from cycle 8
    do_reset();
    for (int i = 0; i < 48; i++) begin
      step(1'b1, (i >= 8), 32'hA0000000 + 32'(i));
      if (i >= 8) check("wrap_dout", data_out, 32'hA0000000 + 32'(i - 8));
      check("wrap_ocup", 32'(ocup), (i < 8) ? 32'(i + 1) : 32'd8);
    end
    step(1'b0, 1'b0, 32'h0);
    check("wrap_final_ocup", 32'(ocup), 32'd8);
    check("wrap_final_error", 32'(error), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
